// File: rtl/cci_mpf_prim_counting_semaphore_cam.sv
// ---------------------------------------------------------------------------
// cci_mpf_prim_counting_semaphore_cam
//
// Small CAM of reference-counted values. A set of a value already present
// bumps its count; a set of an absent value takes the lowest-index free entry.
// A clear decrements the count, and the entry is freed when the count reaches
// zero. Any number of lookup ports report whether a value is currently held.
//
// Optional feature macro: CCI_MPF_SEM_CAM_SET_BYPASS_EN
//   When defined, a set that will be accepted this cycle is also reported on
//   is_set_T0 in the same cycle. Otherwise is_set_T0 reflects registered state
//   only.
//
// Ports:
//   clk              sole clock, rising edge
//   reset            asynchronous, active-high reset
//   rdy              at least one entry is free (combinational)
//   set_en/value     acquire a reference to set_value
//   clear_en/value   release a reference to clear_value
//   test_value[p]    lookup values, one per test port
//   is_set_T0[p]     same-cycle lookup result
//   is_set_T1[p]     is_set_T0 delayed by one cycle
//   n_live           number of valid entries (registered)
//   error_full       sticky: set of an absent value while no entry is free
//   error_overflow   sticky: set would exceed the maximum count
//   error_underflow  sticky: clear of an absent value
// ---------------------------------------------------------------------------
module cci_mpf_prim_counting_semaphore_cam
#(
    parameter int N_ENTRIES    = 16,
    parameter int N_VALUE_BITS = 8,
    parameter int N_COUNT_BITS = 4,
    parameter int N_TEST_PORTS = 2
)
(
    input  logic                                      clk,
    input  logic                                      reset,
    output logic                                      rdy,
    input  logic                                      set_en,
    input  logic [N_VALUE_BITS-1:0]                   set_value,
    input  logic                                      clear_en,
    input  logic [N_VALUE_BITS-1:0]                   clear_value,
    input  logic [N_TEST_PORTS-1:0][N_VALUE_BITS-1:0] test_value,
    output logic [N_TEST_PORTS-1:0]                   is_set_T0,
    output logic [N_TEST_PORTS-1:0]                   is_set_T1,
    output logic [$clog2(N_ENTRIES+1)-1:0]            n_live,
    output logic                                      error_full,
    output logic                                      error_overflow,
    output logic                                      error_underflow
);

    localparam int LIVE_BITS = $clog2(N_ENTRIES + 1);
    localparam logic [N_COUNT_BITS-1:0] COUNT_ZERO = {N_COUNT_BITS{1'b0}};
    localparam logic [N_COUNT_BITS-1:0] COUNT_ONE  = N_COUNT_BITS'(1);
    localparam logic [N_COUNT_BITS-1:0] COUNT_MAX  = {N_COUNT_BITS{1'b1}};

    // Entry storage; an entry is valid exactly when its count is nonzero.
    logic [N_VALUE_BITS-1:0] value_r [N_ENTRIES];
    logic [N_COUNT_BITS-1:0] count_r [N_ENTRIES];

    logic [N_ENTRIES-1:0] valid_s;
    logic [N_ENTRIES-1:0] free_s;
    logic [N_ENTRIES-1:0] alloc_oh_s;
    logic [N_ENTRIES-1:0] set_match_s;
    logic [N_ENTRIES-1:0] clr_match_s;
    logic [N_ENTRIES-1:0] at_max_s;
    logic [N_ENTRIES-1:0] at_one_s;

    logic set_hit_s, clr_hit_s, same_s, set_at_max_s, clr_at_one_s;
    logic inc_s, ovf_s, alloc_s, full_s, dec_s, unf_s, freed_s;

    logic [LIVE_BITS-1:0]    n_live_r, n_live_next_s;
    logic [N_TEST_PORTS-1:0] is_set_t0_s, is_set_t1_r;
    logic                    error_full_r, error_overflow_r, error_underflow_r;

    // Per-entry status and CAM match vectors for the set and clear ports.
    always_comb begin
        valid_s     = {N_ENTRIES{1'b0}};
        set_match_s = {N_ENTRIES{1'b0}};
        clr_match_s = {N_ENTRIES{1'b0}};
        at_max_s    = {N_ENTRIES{1'b0}};
        at_one_s    = {N_ENTRIES{1'b0}};
        for (int i = 0; i < N_ENTRIES; i++) begin
            valid_s[i]     = (count_r[i] != COUNT_ZERO);
            set_match_s[i] = valid_s[i] && (value_r[i] == set_value);
            clr_match_s[i] = valid_s[i] && (value_r[i] == clear_value);
            at_max_s[i]    = (count_r[i] == COUNT_MAX);
            at_one_s[i]    = (count_r[i] == COUNT_ONE);
        end
    end

    assign free_s = ~valid_s;
    // Isolate the lowest set bit of the free vector: x & -x.
    assign alloc_oh_s = free_s & (~free_s + N_ENTRIES'(1));
    assign rdy        = |free_s;

    // Values are unique among valid entries, so each match vector is one-hot.
    assign set_hit_s    = |set_match_s;
    assign clr_hit_s    = |clr_match_s;
    assign set_at_max_s = |(set_match_s & at_max_s);
    assign clr_at_one_s = |(clr_match_s & at_one_s);

    // A set and clear of the same present value cancel, even at max count.
    assign same_s  = set_en && clear_en && set_hit_s && clr_hit_s &&
                     (set_value == clear_value);
    assign inc_s   = set_en && set_hit_s && !same_s && !set_at_max_s;
    assign ovf_s   = set_en && set_hit_s && !same_s && set_at_max_s;
    assign alloc_s = set_en && !set_hit_s && rdy;
    assign full_s  = set_en && !set_hit_s && !rdy;
    assign dec_s   = clear_en && clr_hit_s && !same_s;
    assign unf_s   = clear_en && !clr_hit_s;
    assign freed_s = dec_s && clr_at_one_s;

    // Entry update. The incremented, allocated and decremented entries are
    // always distinct (allocation only targets a pre-edge free entry), so at
    // most one action applies to any entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                value_r[i] <= {N_VALUE_BITS{1'b0}};
                count_r[i] <= COUNT_ZERO;
            end
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (inc_s && set_match_s[i]) begin
                    count_r[i] <= count_r[i] + COUNT_ONE;
                end else if (alloc_s && alloc_oh_s[i]) begin
                    value_r[i] <= set_value;
                    count_r[i] <= COUNT_ONE;
                end else if (dec_s && clr_match_s[i]) begin
                    count_r[i] <= count_r[i] - COUNT_ONE;
                end else begin
                    count_r[i] <= count_r[i];
                end
            end
        end
    end

    // Live-entry count tracks allocations and frees in the same edge.
    always_comb begin
        n_live_next_s = n_live_r;
        if (alloc_s && !freed_s) begin
            n_live_next_s = n_live_r + LIVE_BITS'(1);
        end else if (freed_s && !alloc_s) begin
            n_live_next_s = n_live_r - LIVE_BITS'(1);
        end else begin
            n_live_next_s = n_live_r;
        end
    end

    // Lookup ports against pre-edge state, plus optional set bypass.
    always_comb begin
        is_set_t0_s = {N_TEST_PORTS{1'b0}};
        for (int p = 0; p < N_TEST_PORTS; p++) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                is_set_t0_s[p] = is_set_t0_s[p] |
                                 (valid_s[i] && (value_r[i] == test_value[p]));
            end
`ifdef CCI_MPF_SEM_CAM_SET_BYPASS_EN
            // Only a set that will not be dropped as full is reported early.
            is_set_t0_s[p] = is_set_t0_s[p] |
                             (!reset && set_en && (set_hit_s || rdy) &&
                              (set_value == test_value[p]));
`endif
        end
    end

    // Delayed lookup result, live count and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_set_t1_r       <= {N_TEST_PORTS{1'b0}};
            n_live_r          <= {LIVE_BITS{1'b0}};
            error_full_r      <= 1'b0;
            error_overflow_r  <= 1'b0;
            error_underflow_r <= 1'b0;
        end else begin
            is_set_t1_r       <= is_set_t0_s;
            n_live_r          <= n_live_next_s;
            error_full_r      <= error_full_r | full_s;
            error_overflow_r  <= error_overflow_r | ovf_s;
            error_underflow_r <= error_underflow_r | unf_s;
        end
    end

    assign is_set_T0       = is_set_t0_s;
    assign is_set_T1       = is_set_t1_r;
    assign n_live          = n_live_r;
    assign error_full      = error_full_r;
    assign error_overflow  = error_overflow_r;
    assign error_underflow = error_underflow_r;

endmodule

// File: tb/tb_cci_mpf_prim_counting_semaphore_cam.sv
// ---------------------------------------------------------------------------
// Testbench for cci_mpf_prim_counting_semaphore_cam, built with a 4-entry,
// 2-bit-count configuration so the full and overflow boundaries are reachable.
// Directed scenarios use constant expectations; the random scenario compares
// against a value->count table model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cci_mpf_prim_counting_semaphore_cam;

    localparam int NE   = 4;
    localparam int NV   = 8;
    localparam int NC   = 2;
    localparam int NT   = 2;
    localparam int CMAX = 3;
`ifdef CCI_MPF_SEM_CAM_SET_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   rdy;
    logic                   set_en, clear_en;
    logic [NV-1:0]          set_value, clear_value;
    logic [NT-1:0][NV-1:0]  test_value;
    logic [NT-1:0]          is_set_T0, is_set_T1;
    logic [2:0]             n_live;
    logic                   error_full, error_overflow, error_underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: reference count per value, live-value count, flags.
    int         cnt [256];
    int         live;
    bit         m_full, m_ovf, m_unf;
    bit [NT-1:0] m_t1;

    cci_mpf_prim_counting_semaphore_cam #(
        .N_ENTRIES(NE), .N_VALUE_BITS(NV), .N_COUNT_BITS(NC), .N_TEST_PORTS(NT)
    ) dut (
        .clk(clk), .reset(reset), .rdy(rdy),
        .set_en(set_en), .set_value(set_value),
        .clear_en(clear_en), .clear_value(clear_value),
        .test_value(test_value), .is_set_T0(is_set_T0), .is_set_T1(is_set_T1),
        .n_live(n_live), .error_full(error_full),
        .error_overflow(error_overflow), .error_underflow(error_underflow)
    );

    always #5 clk = ~clk;

    function automatic bit exp_rdy();
        return live < NE;
    endfunction

    function automatic bit exp_t0(int p);
        bit b;
        b = cnt[int'(test_value[p])] > 0;
        if (BYP && !reset && set_en && (set_value == test_value[p]) &&
            ((cnt[int'(set_value)] > 0) || exp_rdy()))
            b = 1'b1;
        return b;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 256; v++) cnt[v] = 0;
        live = 0; m_full = 0; m_ovf = 0; m_unf = 0; m_t1 = '0;
    endtask

    task automatic model_step();
        int sv, cv;
        bit sp, cp, room, same;
        sv   = int'(set_value);
        cv   = int'(clear_value);
        sp   = cnt[sv] > 0;
        cp   = cnt[cv] > 0;
        room = live < NE;
        same = set_en && clear_en && (sv == cv) && sp;
        for (int p = 0; p < NT; p++) m_t1[p] = exp_t0(p);
        if (set_en && !same) begin
            if (sp) begin
                if (cnt[sv] == CMAX) m_ovf = 1; else cnt[sv]++;
            end else if (room) cnt[sv] = 1;
            else m_full = 1;
        end
        if (clear_en && !same) begin
            if (cp) cnt[cv]--; else m_unf = 1;
        end
        live = 0;
        for (int v = 0; v < 256; v++) if (cnt[v] > 0) live++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        #1;
    endtask

    task automatic apply(bit se, int sv, bit ce, int cv, int t0, int t1);
        set_en = se; set_value = NV'(sv);
        clear_en = ce; clear_value = NV'(cv);
        test_value[0] = NV'(t0); test_value[1] = NV'(t1);
        #1;
    endtask

    task automatic do_reset();
        apply(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apply(1, 'h11, 1, 'h11, 'h11, 'h11);
        tick(); tick();
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %0b expected 1", rdy); end
        checks++; if (is_set_T0 !== 2'b00) begin errors++; $display("FAIL reset_t0: got %b expected 00", is_set_T0); end
        checks++; if (is_set_T1 !== 2'b00) begin errors++; $display("FAIL reset_t1: got %b expected 00", is_set_T1); end
        checks++; if (n_live !== 3'd0) begin errors++; $display("FAIL reset_n_live: got %0d expected 0", n_live); end
        checks++; if ({error_full, error_overflow, error_underflow} !== 3'b000) begin errors++; $display("FAIL reset_errors: got %b expected 000", {error_full, error_overflow, error_underflow}); end
        reset = 1'b0;
        apply(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_single_set();
        apply(1, 'h11, 0, 0, 'h11, 'h12);
        checks++; if (is_set_T0 !== {1'b0, BYP}) begin errors++; $display("FAIL set11_t0_same: got %b expected %b", is_set_T0, {1'b0, BYP}); end
        tick();
        apply(0, 'h11, 0, 0, 'h11, 'h12);
        checks++; if (is_set_T0 !== 2'b01) begin errors++; $display("FAIL set11_t0: got %b expected 01", is_set_T0); end
        checks++; if (n_live !== 3'd1) begin errors++; $display("FAIL set11_n_live: got %0d expected 1", n_live); end
        tick();
        checks++; if (is_set_T1 !== 2'b01) begin errors++; $display("FAIL set11_t1: got %b expected 01", is_set_T1); end
    endtask

    task automatic test_refcount();
        do_reset();
        for (int k = 0; k < 3; k++) begin apply(1, 'h22, 0, 0, 'h22, 'h23); tick(); end
        for (int k = 0; k < 2; k++) begin apply(0, 0, 1, 'h22, 'h22, 'h23); tick(); end
        apply(0, 0, 0, 0, 'h22, 'h23);
        checks++; if (is_set_T0 !== 2'b01) begin errors++; $display("FAIL ref22_after2: got %b expected 01", is_set_T0); end
        checks++; if (n_live !== 3'd1) begin errors++; $display("FAIL ref22_n_live1: got %0d expected 1", n_live); end
        apply(0, 0, 1, 'h22, 'h22, 'h23); tick();
        apply(0, 0, 0, 0, 'h22, 'h23);
        checks++; if (is_set_T0 !== 2'b00) begin errors++; $display("FAIL ref22_after3: got %b expected 00", is_set_T0); end
        checks++; if (n_live !== 3'd0) begin errors++; $display("FAIL ref22_n_live0: got %0d expected 0", n_live); end
        checks++; if ({error_full, error_overflow, error_underflow} !== 3'b000) begin errors++; $display("FAIL ref22_errors: got %b expected 000", {error_full, error_overflow, error_underflow}); end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 4; k++) begin apply(1, 'hA0 + k, 0, 0, 0, 0); tick(); end
        apply(0, 0, 0, 0, 'h55, 'hA0);
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL full_rdy: got %0b expected 0", rdy); end
        checks++; if (n_live !== 3'd4) begin errors++; $display("FAIL full_n_live4: got %0d expected 4", n_live); end
        apply(1, 'h55, 1, 'hA0, 'h55, 'hA0);
        checks++; if (is_set_T0 !== 2'b10) begin errors++; $display("FAIL full_t0_same: got %b expected 10", is_set_T0); end
        tick();
        apply(0, 0, 0, 0, 'h55, 'hA0);
        checks++; if (error_full !== 1'b1) begin errors++; $display("FAIL full_error: got %0b expected 1", error_full); end
        checks++; if (is_set_T0 !== 2'b00) begin errors++; $display("FAIL full_55_absent: got %b expected 00", is_set_T0); end
        checks++; if (n_live !== 3'd3) begin errors++; $display("FAIL full_n_live3: got %0d expected 3", n_live); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_after: got %0b expected 1", rdy); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 3; k++) begin apply(1, 'h33, 0, 0, 'h33, 0); tick(); end
        apply(1, 'h33, 1, 'h33, 'h33, 0); tick();
        apply(0, 0, 0, 0, 'h33, 0);
        checks++; if ({error_overflow, error_underflow} !== 2'b00) begin errors++; $display("FAIL ovf_same_no_err: got %b expected 00", {error_overflow, error_underflow}); end
        apply(1, 'h33, 0, 0, 'h33, 0); tick();
        apply(0, 0, 0, 0, 'h33, 0);
        checks++; if (error_overflow !== 1'b1) begin errors++; $display("FAIL ovf_error: got %0b expected 1", error_overflow); end
        for (int k = 0; k < 2; k++) begin apply(0, 0, 1, 'h33, 'h33, 0); tick(); end
        apply(0, 0, 0, 0, 'h33, 0);
        checks++; if (is_set_T0 !== 2'b01) begin errors++; $display("FAIL ovf_after2clr: got %b expected 01", is_set_T0); end
        apply(0, 0, 1, 'h33, 'h33, 0); tick();
        apply(0, 0, 0, 0, 'h33, 0);
        checks++; if (is_set_T0 !== 2'b00) begin errors++; $display("FAIL ovf_after3clr: got %b expected 00", is_set_T0); end
        checks++; if (error_underflow !== 1'b0) begin errors++; $display("FAIL ovf_no_unf: got %0b expected 0", error_underflow); end
    endtask

    task automatic test_underflow_reset();
        do_reset();
        apply(1, 'h10, 0, 0, 'h10, 'h44); tick();
        apply(0, 0, 1, 'h44, 'h10, 'h44); tick();
        apply(0, 0, 0, 0, 'h10, 'h44);
        checks++; if (error_underflow !== 1'b1) begin errors++; $display("FAIL unf_error: got %0b expected 1", error_underflow); end
        checks++; if (n_live !== 3'd1) begin errors++; $display("FAIL unf_n_live: got %0d expected 1", n_live); end
        // Fill the remaining entries so rdy is 0 before the mid-cycle reset.
        for (int k = 0; k < 3; k++) begin apply(1, 'hB0 + k, 0, 0, 'h10, 'h44); tick(); end
        apply(0, 0, 0, 0, 'h10, 'h44);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        checks++; if ({error_full, error_overflow, error_underflow} !== 3'b000) begin errors++; $display("FAIL midrst_errors: got %b expected 000", {error_full, error_overflow, error_underflow}); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL midrst_rdy: got %0b expected 1", rdy); end
        checks++; if (is_set_T0 !== 2'b00) begin errors++; $display("FAIL midrst_t0: got %b expected 00", is_set_T0); end
        apply(1, 'h10, 0, 0, 'h10, 'h44); tick();
        reset = 1'b0;
        apply(0, 0, 0, 0, 'h10, 'h44); tick();
        checks++; if (n_live !== 3'd0) begin errors++; $display("FAIL midrst_n_live: got %0d expected 0", n_live); end
        checks++; if (is_set_T0 !== 2'b00) begin errors++; $display("FAIL midrst_discard: got %b expected 00", is_set_T0); end
    endtask

    task automatic test_bypass();
        do_reset();
        apply(1, 'h66, 0, 0, 'h66, 'h67);
        checks++; if (is_set_T0 !== {1'b0, BYP}) begin errors++; $display("FAIL byp_same: got %b expected %b", is_set_T0, {1'b0, BYP}); end
        tick();
        apply(0, 0, 0, 0, 'h66, 'h67);
        checks++; if (is_set_T0 !== 2'b01) begin errors++; $display("FAIL byp_next: got %b expected 01", is_set_T0); end
        checks++; if (is_set_T1 !== {1'b0, BYP}) begin errors++; $display("FAIL byp_t1: got %b expected %b", is_set_T1, {1'b0, BYP}); end
    endtask

    task automatic test_random();
        bit [NT-1:0] e_t0;
        do_reset();
        for (int it = 0; it < 600; it++) begin
            reset = ($urandom_range(0, 59) == 0);
            if (reset) model_reset();
            apply($urandom_range(0, 1), 'h40 + $urandom_range(0, 5),
                  $urandom_range(0, 1), 'h40 + $urandom_range(0, 5),
                  'h40 + $urandom_range(0, 5), 'h40 + $urandom_range(0, 5));
            for (int p = 0; p < NT; p++) e_t0[p] = exp_t0(p);
            checks++; if (rdy !== exp_rdy()) begin errors++; $display("FAIL rand_rdy @%0d: got %0b expected %0b", it, rdy, exp_rdy()); end
            checks++; if (is_set_T0 !== e_t0) begin errors++; $display("FAIL rand_t0 @%0d: got %b expected %b", it, is_set_T0, e_t0); end
            checks++; if (is_set_T1 !== m_t1) begin errors++; $display("FAIL rand_t1 @%0d: got %b expected %b", it, is_set_T1, m_t1); end
            checks++; if (n_live !== 3'(live)) begin errors++; $display("FAIL rand_n_live @%0d: got %0d expected %0d", it, n_live, live); end
            checks++; if ({error_full, error_overflow, error_underflow} !== {m_full, m_ovf, m_unf}) begin errors++; $display("FAIL rand_errors @%0d: got %b expected %b", it, {error_full, error_overflow, error_underflow}, {m_full, m_ovf, m_unf}); end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_set();
        test_refcount();
        test_full();
        test_overflow();
        test_underflow_reset();
        test_bypass();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
